hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Producer of the pipeline stall and flush controls for the 5-stage CPU.
- Detects three conditions:
  - load-use hazards (ID vs ID/EX),
  - taken-branch flushes (resolved in EX),
  - variable-latency data-memory waits (MEM req/ready handshake).
- Drives:
  - PC and IF/ID write enables,
  - IF/ID flush,
  - the bubble select consumed by the ID/EX control-zeroing mux.
- Holds a MEM-wait FSM with timeout, plus saturating performance counters.

Parameters:
- REG_AW, 5, register index width
- PERF_W, 16, width of each performance counter
- MEM_TIMEOUT, 64, max consecutive MEM-wait cycles before error

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_rs1_i  in  REG_AW  rs1 index of instruction in ID
- id_rs2_i  in  REG_AW  rs2 index of instruction in ID
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- idex_memRead_i  in  1  instruction in EX is a load
- idex_rd_i  in  REG_AW  destination of instruction in EX
- ex_branch_taken_i  in  1  branch/jump resolved taken in EX this cycle
- mem_req_i  in  1  MEM stage issuing a data-memory access
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  clear IF/ID to NOP
- idex_bubble_o  out  1  select zeroed controls into ID/EX (hazard select)
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB registers
- mem_err_o  out  1  sticky MEM timeout flag
- stall_cnt_o  out  PERF_W  load-use stall cycles
- flush_cnt_o  out  PERF_W  branch flush events
- wait_cnt_o  out  PERF_W  MEM-wait cycles

Behaviour:
- Reset (rst_i high at posedge):
  - state to RUN;
  - all counters and mem_err_o to 0;
  - wait timer to 0.
  - While rst_i is high, outputs are forced to pc_write_o=1, ifid_write_o=1, all others 0.
  - Reset mid-wait abandons the wait.
- load_use (combinational): idex_memRead_i & idex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==idex_rd_i) | (id_use_rs2_i & id_rs2_i==idex_rd_i)).
- memwait (combinational): mem_req_i & ~mem_ready_i & ~mem_err_o.
- Priority, evaluated combinationally each cycle:
  1. memwait: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=0, ifid_flush_o=0; wait_cnt_o increments.
  2. ex_branch_taken_i: pc_write_o=1, ifid_flush_o=1, idex_bubble_o=1; load_use is ignored; flush_cnt_o increments.
  3. load_use: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o increments. Exactly one bubble per load-use, because the load leaves EX next cycle.
  4. otherwise: pc_write_o=1, ifid_write_o=1, all others 0.
- FSM (registered):
  - RUN -> WAIT when memwait.
  - WAIT -> RUN when mem_ready_i or ~mem_req_i.
  - In WAIT the timer increments each cycle; it resets to 0 on entering RUN.
  - When the timer reaches MEM_TIMEOUT-1 while still waiting:
    - mem_err_o sets (sticky until reset),
    - FSM returns to RUN,
    - memwait is masked, so the pipeline proceeds and does not deadlock.
- Counters saturate at all-ones; they never wrap.
- Rule for simultaneous memwait and branch: the hold wins. The branch stays in EX, so it is re-presented and flushed on the first non-wait cycle, counted once.
- idex_rd_i==0 never causes a stall (x0).
- All outputs are glitch-free functions of inputs and registered state. No output depends on next-state.

Decomposition:
- Shared package holds:
  - state encoding (ST_RUN, ST_WAIT),
  - REG_AW default,
  - the priority constants.
- Natural sub-module: hazard_sat_counter (PERF_W-wide saturating counter with inc and synchronous clear), instantiated three times.

Test Plan:
- Load-use hit:
  - Stimulus: idex_memRead_i=1, idex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 for one cycle.
  - Required: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o 0->1.
  - With idex_rd_i=0: no stall.
- Branch flush overrides load-use:
  - Stimulus: ex_branch_taken_i=1 with the load-use condition also true.
  - Required: ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; flush_cnt_o=1, stall_cnt_o=0.
- MEM wait of 3 cycles:
  - Stimulus: mem_req_i=1, mem_ready_i=0 for 3 cycles, then ready.
  - Required: pipe_hold_o=1 and pc_write_o=0 for exactly 3 cycles; wait_cnt_o=3; FSM back to RUN.
- MEM timeout with MEM_TIMEOUT=4:
  - Stimulus: mem_ready_i held 0 indefinitely.
  - Required: mem_err_o=1 after the 4th wait cycle; pipe_hold_o=0 thereafter; mem_err_o stays 1 until rst_i.
- Reset mid-wait:
  - Stimulus: assert rst_i during cycle 2 of a wait.
  - Required: next cycle all counters are 0, mem_err_o=0, pc_write_o=1, pipe_hold_o=0.
- Saturation with PERF_W=2:
  - Stimulus: 5 consecutive load-use stalls.
  - Required: stall_cnt_o stays at 3.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared state encoding, defaults and stall-cause priority for the hazard controller.
package hazard_stall_ctrl_pkg;
    localparam int REG_AW_DEF      = 5;
    localparam int PERF_W_DEF      = 16;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    typedef enum logic [1:0] {PRI_NONE, PRI_LOAD_USE, PRI_BRANCH, PRI_MEMWAIT} pri_e;

    function automatic pri_e pick_pri(input logic memwait, input logic branch, input logic load_use);
        return memwait ? PRI_MEMWAIT : branch ? PRI_BRANCH : load_use ? PRI_LOAD_USE : PRI_NONE;
    endfunction
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline hazard inputs and stall/flush/perf outputs of the hazard controller.
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int PERF_W = PERF_W_DEF
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic              idex_memRead_i;
    logic [REG_AW-1:0] idex_rd_i;
    logic              ex_branch_taken_i;
    logic              mem_req_i;
    logic              mem_ready_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              ifid_flush_o;
    logic              idex_bubble_o;
    logic              pipe_hold_o;
    logic              mem_err_o;
    logic [PERF_W-1:0] stall_cnt_o;
    logic [PERF_W-1:0] flush_cnt_o;
    logic [PERF_W-1:0] wait_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, idex_memRead_i, idex_rd_i,
               ex_branch_taken_i, mem_req_i, mem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, mem_err_o,
               stall_cnt_o, flush_cnt_o, wait_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, idex_memRead_i, idex_rd_i,
               ex_branch_taken_i, mem_req_i, mem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, mem_err_o,
               stall_cnt_o, flush_cnt_o, wait_cnt_o
    );
endinterface

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: W-bit event counter that sticks at all-ones, with synchronous clear.
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch-flush / MEM-wait stall and flush control with timeout and perf counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int PERF_W      = PERF_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input logic                clk_i,
    input logic                rst_i,
    hazard_stall_ctrl_if.slave bus
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              err_q, err_d;
    logic              load_use, memwait, timeout;
    pri_e              pri;
    logic [PERF_W-1:0] stall_q, flush_q, wait_q;

    assign load_use = bus.idex_memRead_i && bus.idex_rd_i != REG_AW'(0) &&
                      ((bus.id_use_rs1_i && bus.id_rs1_i == bus.idex_rd_i) ||
                       (bus.id_use_rs2_i && bus.id_rs2_i == bus.idex_rd_i));
    // A latched timeout masks the wait so the pipeline drains instead of deadlocking.
    assign memwait  = bus.mem_req_i && !bus.mem_ready_i && !err_q;
    assign timeout  = memwait && timer_q == TW'(MEM_TIMEOUT - 1);
    assign pri      = pick_pri(memwait, bus.ex_branch_taken_i, load_use);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = (state_q == ST_RUN) ? (memwait ? ST_WAIT : ST_RUN)
                                      : ((bus.mem_ready_i || !bus.mem_req_i) ? ST_RUN : ST_WAIT);
        timer_d = memwait ? timer_q + 1'b1 : '0;
        err_d   = err_q;
        if (timeout) begin
            state_d = ST_RUN;
            timer_d = '0;
            err_d   = 1'b1;
        end
    end

    assign bus.pc_write_o    = rst_i || (pri != PRI_MEMWAIT && pri != PRI_LOAD_USE);
    assign bus.ifid_write_o  = rst_i || (pri != PRI_MEMWAIT && pri != PRI_LOAD_USE);
    assign bus.ifid_flush_o  = !rst_i && pri == PRI_BRANCH;
    assign bus.idex_bubble_o = !rst_i && (pri == PRI_BRANCH || pri == PRI_LOAD_USE);
    assign bus.pipe_hold_o   = !rst_i && pri == PRI_MEMWAIT;
    assign bus.mem_err_o     = !rst_i && err_q;
    assign bus.stall_cnt_o   = rst_i ? '0 : stall_q;
    assign bus.flush_cnt_o   = rst_i ? '0 : flush_q;
    assign bus.wait_cnt_o    = rst_i ? '0 : wait_q;

    hazard_sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk(clk_i), .clr(rst_i), .inc(pri == PRI_LOAD_USE), .cnt(stall_q)
    );
    hazard_sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk(clk_i), .clr(rst_i), .inc(pri == PRI_BRANCH), .cnt(flush_q)
    );
    hazard_sat_counter #(.W(PERF_W)) u_wait_cnt (
        .clk(clk_i), .clr(rst_i), .inc(pri == PRI_MEMWAIT), .cnt(wait_q)
    );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table plus hand sequences against hazard_stall_ctrl (MEM_TIMEOUT=4, PERF_W=2).
module tb_hazard_stall_ctrl;
    localparam int PW  = 2;
    localparam int SAT = (1 << PW) - 1;

    typedef struct {
        int rst, rs1, rs2, u1, u2, mr, rd, br, req, rdy;
        int pcw, ifw, fl, bub, hold, err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   m_stall = 0, m_flush = 0, m_wait = 0;
    vec_t sb[$];
    vec_t tbl[24];

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_AW(5), .PERF_W(PW)) bus ();

    hazard_stall_ctrl #(.REG_AW(5), .PERF_W(PW), .MEM_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e = sb.pop_front();
        chk("pc_write",    32'(bus.pc_write_o),    e.pcw);
        chk("ifid_write",  32'(bus.ifid_write_o),  e.ifw);
        chk("ifid_flush",  32'(bus.ifid_flush_o),  e.fl);
        chk("idex_bubble", 32'(bus.idex_bubble_o), e.bub);
        chk("pipe_hold",   32'(bus.pipe_hold_o),   e.hold);
        chk("mem_err",     32'(bus.mem_err_o),     e.err);
        chk("stall_cnt",   32'(bus.stall_cnt_o),   e.rst != 0 ? 0 : m_stall);
        chk("flush_cnt",   32'(bus.flush_cnt_o),   e.rst != 0 ? 0 : m_flush);
        chk("wait_cnt",    32'(bus.wait_cnt_o),    e.rst != 0 ? 0 : m_wait);
        if (e.rst != 0) begin
            m_stall = 0; m_flush = 0; m_wait = 0;
        end else if (e.hold != 0) m_wait = m_wait < SAT ? m_wait + 1 : SAT;
        else if (e.fl != 0) m_flush = m_flush < SAT ? m_flush + 1 : SAT;
        else if (e.bub != 0) m_stall = m_stall < SAT ? m_stall + 1 : SAT;
    endtask

    task automatic step(input vec_t v);
        rst                   = v.rst[0];
        bus.id_rs1_i          = 5'(v.rs1);
        bus.id_rs2_i          = 5'(v.rs2);
        bus.id_use_rs1_i      = v.u1[0];
        bus.id_use_rs2_i      = v.u2[0];
        bus.idex_memRead_i    = v.mr[0];
        bus.idex_rd_i         = 5'(v.rd);
        bus.ex_branch_taken_i = v.br[0];
        bus.mem_req_i         = v.req[0];
        bus.mem_ready_i       = v.rdy[0];
        sb.push_back(v);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    vec_t idle   = '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0};
    vec_t rst_v  = '{1,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0};
    vec_t wait_v = '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0};
    vec_t rstw_v = '{1,0,0,0,0,0,0,0,1,0, 1,1,0,0,0,0};
    vec_t lu_v   = '{0,0,5,0,1,1,5,0,0,0, 0,0,0,1,0,0};

    initial begin
        tbl = '{
            '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0},
            '{0,0,5,0,1,1,5,0,0,0, 0,0,0,1,0,0},
            '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0},
            '{0,0,0,1,1,1,0,0,0,0, 1,1,0,0,0,0},
            '{0,7,0,0,0,1,7,0,0,0, 1,1,0,0,0,0},
            '{0,7,3,1,1,1,7,0,0,0, 0,0,0,1,0,0},
            '{0,7,0,1,0,0,7,0,0,0, 1,1,0,0,0,0},
            '{0,0,5,0,1,1,5,1,0,0, 1,1,1,1,0,0},
            '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,1, 1,1,0,0,0,0},
            '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0},
            '{0,0,0,0,0,0,0,1,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,1,1,1, 1,1,1,1,0,0},
            '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,0, 0,0,0,0,1,0},
            '{0,0,0,0,0,0,0,0,1,0, 1,1,0,0,0,1},
            '{0,0,5,0,1,1,5,0,1,0, 0,0,0,1,0,1},
            '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,1}
        };
        step(rst_v);
        for (int i = 0; i < 24; i++) step(tbl[i]);
        // Reset on the second cycle of a wait must abandon it and clear everything.
        step(rst_v);
        step(wait_v);
        step(rstw_v);
        step(idle);
        step(wait_v);
        step(idle);
        // Five back-to-back load-use stalls on a 2-bit counter must stick at 3.
        step(rst_v);
        for (int i = 0; i < 5; i++) step(lu_v);
        step(idle);
        chk("stall_sat", 32'(bus.stall_cnt_o), SAT);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
